// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Writes to register 0 are architecturally discarded.
    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Which slot, if any, owns the write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_ACC  = 2'd2
    } grant_e;

endpackage

// File: rtl/write_slot.sv
// One-entry holding slot: valid/ready intake, register-0 drop, clear on grant.
module write_slot
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              inValid,
    input  logic [ADDR_W-1:0] inReg,
    input  logic [DATA_W-1:0] inData,
    input  logic              grant,
    output logic              ready,
    output logic              held,
    output logic              load,
    output logic [ADDR_W-1:0] slotReg,
    output logic [DATA_W-1:0] slotData
);

    // Ready depends only on state, so a new entry can replace one issuing now.
    assign ready = ~held | grant;

    // A register-0 request completes its handshake but is never stored.
    assign load = inValid & ready & (inReg != ADDR_W'(REG_ZERO));

    // Slot storage: load new entry, otherwise release it when it issues.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: the payload is reset as well so nothing downstream ever sees X.
        if (!Rst) begin
            held     <= 1'b0;
            slotReg  <= '0;
            slotData <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            held     <= 1'b1;
            slotReg  <= inReg;
            slotData <= inData;
        end else if (grant) begin
            held     <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline and SAD accelerator.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              pipe_valid,
    input  logic [ADDR_W-1:0] pipe_reg,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_ready,
    input  logic              acc_valid,
    input  logic [ADDR_W-1:0] acc_reg,
    input  logic [DATA_W-1:0] acc_data,
    output logic              acc_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              busy
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic              heldPipe, heldAcc;
    logic              loadPipe, loadAcc;
    logic [ADDR_W-1:0] pipeRegQ, accRegQ;
    logic [DATA_W-1:0] pipeDataQ, accDataQ;
    grant_e            grantSel;
    logic              grantPipe, grantAcc;
    logic              accOlder;
    logic [CNT_W-1:0]  starveCnt;

    write_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) pipeSlot (
        .Clk      (Clk),
        .Rst      (Rst),
        .inValid  (pipe_valid),
        .inReg    (pipe_reg),
        .inData   (pipe_data),
        .grant    (grantPipe),
        .ready    (pipe_ready),
        .held     (heldPipe),
        .load     (loadPipe),
        .slotReg  (pipeRegQ),
        .slotData (pipeDataQ)
    );

    write_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) accSlot (
        .Clk      (Clk),
        .Rst      (Rst),
        .inValid  (acc_valid),
        .inReg    (acc_reg),
        .inData   (acc_data),
        .grant    (grantAcc),
        .ready    (acc_ready),
        .held     (heldAcc),
        .load     (loadAcc),
        .slotReg  (accRegQ),
        .slotData (accDataQ)
    );

    // Pick the winner: same-register hazards by age, else pipeline unless starving.
    always_comb begin
        // NOTE: default assigned first so every path drives grantSel (no latch).
        grantSel = GNT_NONE;
        if (heldPipe && heldAcc) begin
            if (pipeRegQ == accRegQ)
                grantSel = accOlder ? GNT_ACC : GNT_PIPE;
            else if (starveCnt == LIMIT)
                grantSel = GNT_ACC;
            else
                grantSel = GNT_PIPE;
        end else if (heldPipe) begin
            grantSel = GNT_PIPE;
        end else if (heldAcc) begin
            grantSel = GNT_ACC;
        end
    end

    assign grantPipe = (grantSel == GNT_PIPE);
    assign grantAcc  = (grantSel == GNT_ACC);
    assign busy      = heldPipe | heldAcc;

    // Age bit: set means the accelerator entry is older than the pipeline entry.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            accOlder <= 1'b0;
        else if (loadPipe && heldAcc && !grantAcc)
            accOlder <= 1'b1;
        else if (loadAcc && heldPipe && !grantPipe)
            accOlder <= 1'b0;
        else if (grantSel != GNT_NONE)
            accOlder <= 1'b0;
    end

    // Count cycles the accelerator waits while held; saturate at the limit.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            starveCnt <= '0;
        else if (!heldAcc || grantAcc)
            starveCnt <= '0;
        else if (starveCnt != LIMIT)
            starveCnt <= starveCnt + 1'b1;
    end

    // Registered write port; index/data hold their last value when idle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (grantSel != GNT_NONE) begin
            RegWrite      <= 1'b1;
            WriteRegister <= grantAcc ? accRegQ  : pipeRegQ;
            WriteData     <= grantAcc ? accDataQ : pipeDataQ;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus random traffic against a per-register ordering model.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SL = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          pipe_valid, acc_valid;
    logic [AW-1:0] pipe_reg, acc_reg;
    logic [DW-1:0] pipe_data, acc_data;
    logic          pipe_ready, acc_ready;
    logic          RegWrite, busy;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .pipe_valid    (pipe_valid),
        .pipe_reg      (pipe_reg),
        .pipe_data     (pipe_data),
        .pipe_ready    (pipe_ready),
        .acc_valid     (acc_valid),
        .acc_reg       (acc_reg),
        .acc_data      (acc_data),
        .acc_ready     (acc_ready),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .busy          (busy)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid = 1'b0;
        acc_valid  = 1'b0;
    endtask

    // Reference model: every accepted non-zero write is queued per register in
    // acceptance order (pipeline first on a shared edge); each issued write must
    // be the oldest outstanding one for its register, within a bounded delay.
    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } ent_t;

    ent_t expQ [32][$];
    int   pending = 0;
    int   cycleNo = 0;

    task automatic sbMonitor();
        ent_t e;
        int   r;
        if (RegWrite) begin
            r = int'(WriteRegister);
            check("rnd_write_expected", expQ[r].size() != 0, 1);
            if (expQ[r].size() != 0) begin
                e = expQ[r].pop_front();
                pending--;
                check("rnd_write_data", WriteData, e.data);
                check("rnd_write_latency", (cycleNo - e.cyc) <= 12, 1);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && busy; i++) step();
        check(tag, busy, 0);
        step();
    endtask

    logic          rdy;
    int            readyLow, accEdge;
    logic [DW-1:0] pd;
    logic [DW-1:0] wdAt [10];
    logic          pa, aa, lastPa, lastAa;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Rst = 1'b0;
        idle();
        pipe_reg = '0; pipe_data = '0; acc_reg = '0; acc_data = '0;
        step(); step();
        check("reset_regwrite", RegWrite, 0);
        check("reset_busy", busy, 0);
        @(negedge Clk) Rst = 1'b1;
        step();
        check("reset_pipe_ready", pipe_ready, 1);
        check("reset_acc_ready", acc_ready, 1);
        check("reset_wreg", WriteRegister, 0);
        check("reset_wdata", WriteData, 0);

        // Single pipeline write.
        pipe_valid = 1'b1; pipe_reg = 5'd16; pipe_data = 32'hAA;
        step();
        idle();
        check("single_no_write_yet", RegWrite, 0);
        check("single_busy", busy, 1);
        step();
        check("single_regwrite", RegWrite, 1);
        check("single_wreg", WriteRegister, 16);
        check("single_wdata", WriteData, 32'hAA);
        check("single_busy_clear", busy, 0);
        step();
        check("single_regwrite_drop", RegWrite, 0);
        check("single_wreg_hold", WriteRegister, 16);

        // Register 0 requests are handshaken but never written.
        pipe_valid = 1'b1; pipe_reg = 5'd0; pipe_data = 32'hDEAD;
        for (int k = 0; k < 3; k++) begin
            check("reg0_ready", pipe_ready, 1);
            step();
            check("reg0_no_write", RegWrite, 0);
            check("reg0_busy", busy, 0);
        end
        idle();
        step();
        check("reg0_no_write_after", RegWrite, 0);

        // Same register loaded on one edge: pipeline first, accelerator last.
        pipe_valid = 1'b1; pipe_reg = 5'd18; pipe_data = 32'h1;
        acc_valid  = 1'b1; acc_reg  = 5'd18; acc_data  = 32'h2;
        step();
        idle();
        check("same_wait", RegWrite, 0);
        step();
        check("same_first_we", RegWrite, 1);
        check("same_first_data", WriteData, 32'h1);
        step();
        check("same_second_we", RegWrite, 1);
        check("same_second_reg", WriteRegister, 18);
        check("same_second_data", WriteData, 32'h2);
        step();
        check("same_done", RegWrite, 0);

        // Accelerator entry for reg 20 is older than a later pipeline entry.
        pipe_valid = 1'b1; pipe_reg = 5'd9;  pipe_data = 32'h77;
        acc_valid  = 1'b1; acc_reg  = 5'd20; acc_data  = 32'h5;
        step();
        acc_valid = 1'b0;
        pipe_reg = 5'd20; pipe_data = 32'h6;
        step();
        pipe_valid = 1'b0;
        check("age_first_reg", WriteRegister, 9);
        check("age_first_data", WriteData, 32'h77);
        step();
        check("age_acc_reg", WriteRegister, 20);
        check("age_acc_data", WriteData, 32'h5);
        step();
        check("age_pipe_we", RegWrite, 1);
        check("age_pipe_data", WriteData, 32'h6);
        drain("age_drain");

        // Starvation escape: pipeline streams reg 9, accelerator waits on reg 23.
        pd = 32'h100;
        pipe_valid = 1'b1; pipe_reg = 5'd9;  pipe_data = pd;
        acc_valid  = 1'b1; acc_reg  = 5'd23; acc_data  = 32'h1234;
        step();
        acc_valid = 1'b0;
        pd++; pipe_data = pd;
        readyLow = 0; accEdge = 0;
        for (int k = 2; k <= 8; k++) begin
            rdy = pipe_ready;
            if (!rdy) readyLow++;
            step();
            wdAt[k] = WriteData;
            if (RegWrite && WriteRegister == 5'd23) accEdge = k;
            if (rdy) begin pd++; pipe_data = pd; end
        end
        idle();
        check("starve_grant_edge", accEdge, 6);
        check("starve_ready_low_cycles", readyLow, 1);
        check("starve_pipe_first", wdAt[2], 32'h100);
        check("starve_pipe_last_before", wdAt[5], 32'h103);
        check("starve_acc_data", wdAt[6], 32'h1234);
        check("starve_pipe_resume", wdAt[7], 32'h104);
        drain("starve_drain");

        // Asynchronous reset with both slots holding entries.
        pipe_valid = 1'b1; pipe_reg = 5'd3; pipe_data = 32'h33;
        acc_valid  = 1'b1; acc_reg  = 5'd4; acc_data  = 32'h44;
        step();
        acc_valid = 1'b0;
        pipe_reg = 5'd5; pipe_data = 32'h55;
        step();
        idle();
        check("rstmid_pre_we", RegWrite, 1);
        check("rstmid_pre_busy", busy, 1);
        #2 Rst = 1'b0;
        #1;
        check("rstmid_we", RegWrite, 0);
        check("rstmid_busy", busy, 0);
        step();
        @(negedge Clk) Rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rstmid_after_we", RegWrite, 0);
            check("rstmid_after_pready", pipe_ready, 1);
            check("rstmid_after_aready", acc_ready, 1);
        end

        // Random traffic, small register range to provoke hazards.
        lastPa = 1'b1; lastAa = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!pipe_valid || lastPa) begin
                pipe_valid = ($urandom_range(0, 99) < 60);
                pipe_reg   = AW'($urandom_range(0, 7));
                pipe_data  = $urandom;
            end
            if (!acc_valid || lastAa) begin
                acc_valid = ($urandom_range(0, 99) < 50);
                acc_reg   = AW'($urandom_range(0, 7));
                acc_data  = $urandom;
            end
            pa = pipe_valid & pipe_ready;
            aa = acc_valid & acc_ready;
            step();
            cycleNo++;
            sbMonitor();
            if (pa && pipe_reg != 0) begin
                expQ[pipe_reg].push_back('{data: pipe_data, cyc: cycleNo});
                pending++;
            end
            if (aa && acc_reg != 0) begin
                expQ[acc_reg].push_back('{data: acc_data, cyc: cycleNo});
                pending++;
            end
            check("rnd_busy", busy, pending != 0);
            lastPa = pa;
            lastAa = aa;
        end
        idle();
        for (int i = 0; i < 30 && pending != 0; i++) begin
            step();
            cycleNo++;
            sbMonitor();
        end
        check("rnd_drain_pending", pending, 0);
        check("rnd_drain_busy", busy, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (RegWrite / WriteRegister / WriteData) between two writers: the pipeline writeback stage and the SAD accelerator writeback.
- Each writer gets a one-entry holding slot with a valid/ready handshake.
- Fixed priority goes to the pipeline, with a starvation escape for the accelerator and age-ordered issue when both target the same register.
- Outputs are registered and drive the register file write inputs directly.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width
STARVE_LIMIT, 4, consecutive cycles the accelerator may be held un-granted before it is forced (1..15)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous reset, active-low
pipe_valid  in  1  pipeline write request
pipe_reg  in  ADDR_W  pipeline destination register
pipe_data  in  DATA_W  pipeline write data
pipe_ready  out  1  pipeline slot can accept this cycle
acc_valid  in  1  accelerator write request
acc_reg  in  ADDR_W  accelerator destination register
acc_data  in  DATA_W  accelerator write data
acc_ready  out  1  accelerator slot can accept this cycle
RegWrite  out  1  register-file write enable (registered)
WriteRegister  out  ADDR_W  register-file write index (registered)
WriteData  out  DATA_W  register-file write data (registered)
busy  out  1  either slot holds an entry

Behaviour:
- Reset (Rst=0, asynchronous):
  - Both slots empty, age bit 0, starve_cnt 0.
  - RegWrite 0, WriteRegister 0, WriteData 0, busy 0.
  - pipe_ready = acc_ready = 1 once Rst deasserts.
  - Reset mid-operation discards held entries with no write issued.
- Accept: slot X loads {reg, data} at the rising edge when X_valid & X_ready.
  - X_ready = ~held_X | grant_X. It depends only on state, never on X_valid, so back-to-back accepts at one per cycle are supported.
- Register 0: a request to reg 0 is handshaken (ready honoured) but is not stored. It never produces RegWrite.
- Grant, computed each cycle from held slots:
  - Only one held: that slot.
  - Both held, same reg: older slot wins, by age bit. If both were loaded on the same edge, pipeline is treated as older, so the accelerator's value is the final one.
  - Both held, different reg, starve_cnt == STARVE_LIMIT: accelerator wins.
  - Both held, different reg, otherwise: pipeline wins.
- Issue: at the edge after a grant, output registers load the winner and RegWrite=1. The winning slot clears at that same edge unless refilled.
  - With no grant, RegWrite=0 next cycle; WriteRegister/WriteData hold their last values.
- Latency: accept at edge N, then RegWrite high during cycle N+1..N+2 (granted at cycle N+1 if uncontended). The register file commits at edge N+2.
- Throughput: one write per cycle total.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle the accelerator is held and not granted.
  - Clears on accelerator grant or when the accelerator slot is empty.
- Age bit: set when one slot loads while the other is already held, marking the held one older. Cleared when either slot issues.
- busy = held_pipe | held_acc.

Decomposition:
- Shared package `regfile_arb_pkg`:
  - DATA_W/ADDR_W defaults
  - REG_ZERO constant (5'd0)
  - grant encoding constants GNT_NONE / GNT_PIPE / GNT_ACC
- One sub-module, `write_slot`:
  - one-entry holding register with valid/ready, reg-0 drop and clear-on-grant
  - instantiated twice
- Arbitration, age and starvation logic plus output registers stay in the top.

Test Plan:
- Reset: Rst=0 mid-stream with both slots held → RegWrite=0 immediately. After release, no write issues and both ready=1.
- Single write: pipe writes reg 16 = 0x0000_00AA, accepted at edge N → RegWrite=1, WriteRegister=16, WriteData=0xAA in cycle N+1..N+2, then RegWrite=0.
- Priority and starvation, STARVE_LIMIT=4:
  - Stimulus: pipeline streams writes to reg 9 every cycle; accelerator holds reg 23 = 0x1234.
  - Response: acc is granted on the 5th contended cycle and pipe_ready=0 for exactly one cycle.
- Same-register ordering: both load reg 18 on the same edge (pipe 0x1, acc 0x2) → issues 0x1 then 0x2 on consecutive cycles; final reg 18 = 0x2.
- Age ordering: acc holds reg 20 = 0x5, blocked; pipe then loads reg 20 = 0x6 → acc issues first, final value 0x6.
- Reg 0 drop: pipe_valid with pipe_reg=0 for 3 cycles → pipe_ready stays 1, RegWrite never asserts, busy stays 0.
